call_stack: RTL and testbench
=============================

CALL_STACK -- requirements
Module: call_stack

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of 16-bit return-address entries (power of 2, 2..64).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-low (asserted when 0).
REQ-004 SHALL have port call, input, 1, push request: save pc_in as return address.
REQ-005 SHALL have port ret, input, 1, pop request: return top address to the program counter.
REQ-006 SHALL have port pc_in, input, 16, current program-counter value sampled on call.
REQ-007 SHALL have port bus, output, 16, popped return address, valid while pc_write=1, else 16'h0000.
REQ-008 SHALL have port pc_write, output, 1, one-cycle load strobe to the program counter.
REQ-009 SHALL have ports empty and full, output, 1 each, stack occupancy flags.
REQ-010 SHALL have port depth, output, $clog2(DEPTH)+1, current entry count.
REQ-011 SHALL have ports ovf_err and unf_err, output, 1 each, sticky error flags (see REQ-027).
REQ-012 SHALL have port err_clr, input, 1, clears sticky error flags.

Function
REQ-013 Storage SHALL be a DEPTH x 16 register array plus a stack pointer sp (= depth), registered.
REQ-014 call alone, not full: mem[sp] <= pc_in, sp <= sp+1, next cycle.
REQ-015 ret alone, not empty: sp <= sp-1; next cycle pc_write=1, bus=mem[sp-1] (value captured into output register at the accept edge).
REQ-016 Latency ret-to-pc_write SHALL be exactly 1 cycle; pc_write SHALL be high for exactly 1 cycle per accepted ret.
REQ-017 Back-to-back ret on consecutive cycles SHALL yield pc_write on consecutive cycles with successive entries.
REQ-018 call and ret together, not empty: top entry replaced by pc_in, sp unchanged, next cycle pc_write=1 with old top on bus.
REQ-019 call and ret together, empty: call performed (push pc_in), ret dropped, unf_err set, no pc_write.
REQ-020 call when full (ret=0): ignored, contents and sp unchanged, ovf_err set.
REQ-021 ret when empty (call=0): ignored, no pc_write, unf_err set.
REQ-022 empty=(sp==0), full=(sp==DEPTH), both combinational from sp; depth=sp.
REQ-023 No wrap-around: sp SHALL never exceed DEPTH nor go below 0.
REQ-024 err_clr SHALL clear both flags; a new error in the same cycle as err_clr SHALL win (flag set).

Reset
REQ-025 rst=0 at clock edge: sp=0, pc_write=0, bus=16'h0000, ovf_err=0, unf_err=0; empty=1, full=0, depth=0.
REQ-026 Reset mid-operation SHALL cancel any pc_write due in the following cycle; array contents need not be cleared.

Configuration
REQ-027 Macro CALL_STACK_ERR_EN defined: ovf_err/unf_err/err_clr behave per REQ-019..REQ-024.
REQ-028 Macro CALL_STACK_ERR_EN undefined: ovf_err and unf_err SHALL be constant 0, err_clr ignored; all other behaviour (dropped call/ret) unchanged.

Verification (DEPTH=4, CALL_STACK_ERR_EN defined)
REQ-029 Reset then call with pc_in=16'h0010,0x0020,0x0030 -> depth=3; ret x3 back-to-back -> pc_write on 3 consecutive cycles, bus=0x0030,0x0020,0x0010, then empty=1.
REQ-030 Push 0x0001..0x0004 -> full=1; call pc_in=0x0005 -> ovf_err=1, depth=4; ret -> bus=0x0004 (not 0x0005).
REQ-031 Empty stack, ret -> no pc_write, unf_err=1; err_clr -> unf_err=0 next cycle; err_clr with ret on empty -> unf_err stays 1.
REQ-032 Stack holds 0x00A0; call+ret same cycle pc_in=0x00B0 -> pc_write, bus=0x00A0, depth=1; ret -> bus=0x00B0.
REQ-033 Empty stack, call+ret with pc_in=0x0040 -> depth=1, unf_err=1, no pc_write.
REQ-034 depth=2, ret accepted, rst=0 next edge -> pc_write=0, depth=0, bus=0x0000, flags clear.

Source files
------------

// File: rtl/call_stack.sv
// -----------------------------------------------------------------------------
// call_stack
//   Hardware return-address stack for a small processor core.
//   A call pushes the current program counter. A ret pops the top entry and
//   presents it to the program counter for exactly one cycle.
//
// Parameters
//   DEPTH      number of 16-bit return-address entries (power of 2, 2..64)
//
// Ports
//   clk        single clock; all state updates on the rising edge
//   rst        synchronous reset, active low
//   call       push request: save pc_in as a return address
//   ret        pop request: return the top address to the program counter
//   pc_in      program-counter value sampled on call
//   bus        popped return address while pc_write=1, else 16'h0000
//   pc_write   one-cycle load strobe to the program counter
//   empty      stack holds no entries (combinational from sp)
//   full       stack holds DEPTH entries (combinational from sp)
//   depth      current entry count (equals sp)
//   ovf_err    sticky: call seen while full
//   unf_err    sticky: ret seen while empty
//   err_clr    clears both sticky flags
//
// Configuration
//   CALL_STACK_ERR_EN  when defined, ovf_err/unf_err are live sticky flags
//                      cleared by err_clr. When undefined, both flags are
//                      constant 0 and err_clr is ignored. Dropped calls and
//                      rets behave the same in both builds.
// -----------------------------------------------------------------------------
module call_stack #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       call,
  input  logic                       ret,
  input  logic [15:0]                pc_in,
  output logic [15:0]                bus,
  output logic                       pc_write,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       ovf_err,
  output logic                       unf_err,
  input  logic                       err_clr
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;
  localparam logic [SPW-1:0] FULL_SP = SPW'(DEPTH);

  // Storage and stack pointer.
  logic [15:0]    mem_q [DEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic [15:0]    bus_q, bus_d;
  logic           pc_write_q, pc_write_d;

  // Decoded operation.
  logic           is_empty, is_full;
  logic           do_pop, do_push, do_replace;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [AW-1:0]  top_idx;
  logic           ovf_set, unf_set;

  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == FULL_SP);
  assign top_idx  = AW'(sp_q - 1'b1);

  always_comb begin
    // A ret is only honoured when there is something to pop. When call and
    // ret coincide on a non-empty stack, the top entry is overwritten in
    // place. On an empty stack the call still goes ahead and the ret is
    // dropped. A full stack never satisfies call-only, so no wrap is possible.
    do_pop     = ret && !is_empty;
    do_replace = call && do_pop;
    do_push    = call && !ret && !is_full;
    if (call && ret && is_empty) begin
      do_push = 1'b1;
    end

    wr_en   = do_push || do_replace;
    wr_addr = do_replace ? top_idx : sp_q[AW-1:0];

    sp_d = sp_q;
    if (do_push) begin
      sp_d = sp_q + 1'b1;
    end else if (do_pop && !do_replace) begin
      sp_d = sp_q - 1'b1;
    end

    // The popped value is captured at the accept edge so that the program
    // counter sees it exactly one cycle after ret.
    pc_write_d = do_pop;
    bus_d      = do_pop ? mem_q[top_idx] : 16'h0000;

    ovf_set = call && !ret && is_full;
    unf_set = ret && is_empty;
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sp_q       <= '0;
      pc_write_q <= 1'b0;
      bus_q      <= 16'h0000;
    end else begin
      sp_q       <= sp_d;
      pc_write_q <= pc_write_d;
      bus_q      <= bus_d;
    end
  end

  // Entry array. Contents are not reset; writes are blocked while in reset so
  // a call held during reset cannot leave a stale entry behind.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst && wr_en && (wr_addr == AW'(gi))) begin
          mem_q[gi] <= pc_in;
        end
      end
    end
  endgenerate

`ifdef CALL_STACK_ERR_EN
  logic ovf_err_q, ovf_err_d;
  logic unf_err_q, unf_err_d;

  // A new error in the same cycle as err_clr wins over the clear.
  always_comb begin
    ovf_err_d = (ovf_err_q && !err_clr) || ovf_set;
    unf_err_d = (unf_err_q && !err_clr) || unf_set;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_err_q <= 1'b0;
      unf_err_q <= 1'b0;
    end else begin
      ovf_err_q <= ovf_err_d;
      unf_err_q <= unf_err_d;
    end
  end

  assign ovf_err = ovf_err_q;
  assign unf_err = unf_err_q;
`else
  // Error reporting is compiled out; the detect terms and err_clr are unused.
  logic unused_err_sigs;
  assign unused_err_sigs = ovf_set ^ unf_set ^ err_clr;
  assign ovf_err = 1'b0;
  assign unf_err = 1'b0;
`endif

  assign empty    = is_empty;
  assign full     = is_full;
  assign depth    = sp_q;
  assign bus      = bus_q;
  assign pc_write = pc_write_q;

endmodule

// File: tb/tb_call_stack.sv
// -----------------------------------------------------------------------------
// tb_call_stack
//   Directed self-checking bench for call_stack at DEPTH=4. Expected error
//   flag values follow whether CALL_STACK_ERR_EN is defined for the build.
// -----------------------------------------------------------------------------
module tb_call_stack;

  localparam int DEPTH = 4;

`ifdef CALL_STACK_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        call;
  logic        ret;
  logic [15:0] pc_in;
  logic [15:0] bus;
  logic        pc_write;
  logic        empty;
  logic        full;
  logic [2:0]  depth;
  logic        ovf_err;
  logic        unf_err;
  logic        err_clr;

  int pass_cnt;
  int total_cnt;

  call_stack #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .call     (call),
    .ret      (ret),
    .pc_in    (pc_in),
    .bus      (bus),
    .pc_write (pc_write),
    .empty    (empty),
    .full     (full),
    .depth    (depth),
    .ovf_err  (ovf_err),
    .unf_err  (unf_err),
    .err_clr  (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    call = 1'b0; ret = 1'b0; err_clr = 1'b0; pc_in = 16'h0000;
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic push(input logic [15:0] v);
    call = 1'b1; pc_in = v;
    tick();
    call = 1'b0;
    $display("call pc_in=%h depth=%0d", v, depth);
  endtask

  task automatic test_reset();
    rst = 1'b0; call = 1'b0; ret = 1'b0; err_clr = 1'b0; pc_in = 16'h0000;
    tick(); tick();
    total_cnt++; if (pc_write !== 1'b0) $display("FAIL rst_pcw got %b want 0", pc_write); else pass_cnt++;
    total_cnt++; if (bus !== 16'h0000) $display("FAIL rst_bus got %h want 0000", bus); else pass_cnt++;
    total_cnt++; if (depth !== 3'd0) $display("FAIL rst_depth got %0d want 0", depth); else pass_cnt++;
    total_cnt++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL rst_flags got empty=%b full=%b want 1/0", empty, full); else pass_cnt++;
    total_cnt++; if (ovf_err !== 1'b0 || unf_err !== 1'b0) $display("FAIL rst_err got %b%b want 00", ovf_err, unf_err); else pass_cnt++;
    rst = 1'b1;
    $display("reset done");
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_v [3];
    exp_v[0] = 16'h0030; exp_v[1] = 16'h0020; exp_v[2] = 16'h0010;
    do_reset();
    push(16'h0010); push(16'h0020); push(16'h0030);
    total_cnt++; if (depth !== 3'd3) $display("FAIL b2b_depth got %0d want 3", depth); else pass_cnt++;
    ret = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("ret %0d pc_write=%b bus=%h", i, pc_write, bus);
      total_cnt++; if (pc_write !== 1'b1 || bus !== exp_v[i]) $display("FAIL b2b_ret%0d got pcw=%b bus=%h want 1/%h", i, pc_write, bus, exp_v[i]); else pass_cnt++;
      total_cnt++; if (depth !== 3'(2 - i)) $display("FAIL b2b_depth%0d got %0d want %0d", i, depth, 2 - i); else pass_cnt++;
    end
    ret = 1'b0;
    tick();
    total_cnt++; if (pc_write !== 1'b0 || bus !== 16'h0000) $display("FAIL b2b_idle got pcw=%b bus=%h want 0/0000", pc_write, bus); else pass_cnt++;
    total_cnt++; if (empty !== 1'b1) $display("FAIL b2b_empty got %b want 1", empty); else pass_cnt++;
  endtask

  task automatic test_overflow();
    do_reset();
    push(16'h0001); push(16'h0002); push(16'h0003);
    total_cnt++; if (full !== 1'b0) $display("FAIL ovf_notfull got %b want 0", full); else pass_cnt++;
    push(16'h0004);
    total_cnt++; if (full !== 1'b1 || depth !== 3'd4) $display("FAIL ovf_full got full=%b depth=%0d want 1/4", full, depth); else pass_cnt++;
    total_cnt++; if (ovf_err !== 1'b0) $display("FAIL ovf_pre got %b want 0", ovf_err); else pass_cnt++;
    push(16'h0005);
    total_cnt++; if (ovf_err !== ERR_EN || depth !== 3'd4) $display("FAIL ovf_set got ovf=%b depth=%0d want %b/4", ovf_err, depth, ERR_EN); else pass_cnt++;
    ret = 1'b1;
    tick();
    ret = 1'b0;
    $display("ret pc_write=%b bus=%h", pc_write, bus);
    total_cnt++; if (pc_write !== 1'b1 || bus !== 16'h0004) $display("FAIL ovf_ret got pcw=%b bus=%h want 1/0004", pc_write, bus); else pass_cnt++;
    // err_clr on its own clears the overflow flag.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total_cnt++; if (ovf_err !== 1'b0) $display("FAIL ovf_clr got %b want 0", ovf_err); else pass_cnt++;
  endtask

  task automatic test_underflow();
    do_reset();
    ret = 1'b1;
    tick();
    ret = 1'b0;
    $display("ret on empty pc_write=%b unf_err=%b", pc_write, unf_err);
    total_cnt++; if (pc_write !== 1'b0) $display("FAIL unf_pcw got %b want 0", pc_write); else pass_cnt++;
    total_cnt++; if (unf_err !== ERR_EN) $display("FAIL unf_set got %b want %b", unf_err, ERR_EN); else pass_cnt++;
    total_cnt++; if (depth !== 3'd0) $display("FAIL unf_depth got %0d want 0", depth); else pass_cnt++;
    err_clr = 1'b1;
    tick();
    total_cnt++; if (unf_err !== 1'b0) $display("FAIL unf_clr got %b want 0", unf_err); else pass_cnt++;
    ret = 1'b1;
    tick();
    ret = 1'b0; err_clr = 1'b0;
    total_cnt++; if (unf_err !== ERR_EN || pc_write !== 1'b0) $display("FAIL unf_clr_wins got unf=%b pcw=%b want %b/0", unf_err, pc_write, ERR_EN); else pass_cnt++;
  endtask

  task automatic test_call_ret();
    do_reset();
    push(16'h00A0);
    call = 1'b1; ret = 1'b1; pc_in = 16'h00B0;
    tick();
    call = 1'b0; ret = 1'b0;
    $display("call+ret pc_write=%b bus=%h depth=%0d", pc_write, bus, depth);
    total_cnt++; if (pc_write !== 1'b1 || bus !== 16'h00A0) $display("FAIL cr_pop got pcw=%b bus=%h want 1/00a0", pc_write, bus); else pass_cnt++;
    total_cnt++; if (depth !== 3'd1) $display("FAIL cr_depth got %0d want 1", depth); else pass_cnt++;
    ret = 1'b1;
    tick();
    ret = 1'b0;
    total_cnt++; if (pc_write !== 1'b1 || bus !== 16'h00B0) $display("FAIL cr_top got pcw=%b bus=%h want 1/00b0", pc_write, bus); else pass_cnt++;
    total_cnt++; if (unf_err !== 1'b0) $display("FAIL cr_noerr got %b want 0", unf_err); else pass_cnt++;
  endtask

  task automatic test_call_ret_empty();
    do_reset();
    call = 1'b1; ret = 1'b1; pc_in = 16'h0040;
    tick();
    call = 1'b0; ret = 1'b0;
    $display("call+ret on empty pc_write=%b depth=%0d unf_err=%b", pc_write, depth, unf_err);
    total_cnt++; if (depth !== 3'd1 || pc_write !== 1'b0) $display("FAIL cre_push got depth=%0d pcw=%b want 1/0", depth, pc_write); else pass_cnt++;
    total_cnt++; if (unf_err !== ERR_EN) $display("FAIL cre_unf got %b want %b", unf_err, ERR_EN); else pass_cnt++;
    ret = 1'b1;
    tick();
    ret = 1'b0;
    total_cnt++; if (pc_write !== 1'b1 || bus !== 16'h0040) $display("FAIL cre_pop got pcw=%b bus=%h want 1/0040", pc_write, bus); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    ret = 1'b1;  // set unf_err first so the reset has a flag to clear
    tick();
    ret = 1'b0;
    push(16'h0111); push(16'h0222);
    ret = 1'b1;
    tick();
    ret = 1'b0;
    total_cnt++; if (pc_write !== 1'b1 || bus !== 16'h0222) $display("FAIL rm_pop got pcw=%b bus=%h want 1/0222", pc_write, bus); else pass_cnt++;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    $display("mid reset pc_write=%b depth=%0d bus=%h", pc_write, depth, bus);
    total_cnt++; if (pc_write !== 1'b0 || bus !== 16'h0000) $display("FAIL rm_out got pcw=%b bus=%h want 0/0000", pc_write, bus); else pass_cnt++;
    total_cnt++; if (depth !== 3'd0 || empty !== 1'b1) $display("FAIL rm_depth got depth=%0d empty=%b want 0/1", depth, empty); else pass_cnt++;
    total_cnt++; if (ovf_err !== 1'b0 || unf_err !== 1'b0) $display("FAIL rm_err got %b%b want 00", ovf_err, unf_err); else pass_cnt++;
    // ret accepted on the same edge as reset must not produce a strobe.
    push(16'h0333);
    ret = 1'b1; rst = 1'b0;
    tick();
    ret = 1'b0; rst = 1'b1;
    total_cnt++; if (pc_write !== 1'b0 || depth !== 3'd0) $display("FAIL rm_same got pcw=%b depth=%0d want 0/0", pc_write, depth); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst = 1'b0; call = 1'b0; ret = 1'b0; err_clr = 1'b0; pc_in = 16'h0000;
    test_reset();
    test_back_to_back();
    test_overflow();
    test_underflow();
    test_call_ret();
    test_call_ret_empty();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
